// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D unified-memory arbiter.
// Holds the FSM state encoding, owner constants and default widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int CNT_W_DEF        = 16;
  localparam int MAX_D_STREAK_DEF = 4;
  localparam int TIMEOUT_DEF      = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of I-side, D-side and memory-side signals around the arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic              i_ack_o;
  logic [DATA_W-1:0] i_rdata_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_ack_o;
  logic [DATA_W-1:0] d_rdata_o;

  logic              err_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  logic [CNT_W-1:0]  i_cnt_o;
  logic [CNT_W-1:0]  d_cnt_o;

  modport slave (
    input  i_req_i, i_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  mem_ack_i, mem_rdata_i,
    output i_ack_o, i_rdata_o, d_ack_o, d_rdata_o, err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output i_cnt_o, d_cnt_o
  );

  modport master (
    output i_req_i, i_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output mem_ack_i, mem_rdata_i,
    input  i_ack_o, i_rdata_o, d_ack_o, d_rdata_o, err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  i_cnt_o, d_cnt_o
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between I-fetch and D-access; D wins unless I was passed over MAX_D_STREAK times.
// Grant to mem_req 1 cycle, ack 1 cycle after mem_ack_i; requesters hold req until ack, timeout yields err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TO_LIMIT   = TW'(TIMEOUT);

  state_t            state_q, state_d;
  logic              grant, grant_side, timeout_hit;

  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [SW-1:0]     streak_q;
  logic [TW-1:0]     tcnt_q;
  logic [CNT_W-1:0]  i_cnt_q, d_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    grant_side  = OWN_D;
    timeout_hit = 1'b0;

    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.i_ack_o     = 1'b0;
    bus.i_rdata_o   = '0;
    bus.d_ack_o     = 1'b0;
    bus.d_rdata_o   = '0;
    bus.err_o       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_req_i || bus.d_req_i) begin
          grant   = 1'b1;
          state_d = BUSY;
          // I takes the port only when D is idle or I has been passed over too often.
          if (bus.d_req_i && !(bus.i_req_i && streak_q == STREAK_MAX)) grant_side = OWN_D;
          else                                                        grant_side = OWN_I;
        end
      end
      BUSY: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = we_q;
        bus.mem_addr_o  = addr_q;
        bus.mem_wdata_o = wdata_q;
        if (bus.mem_ack_i) begin
          state_d = RESP;
        end else if (tcnt_q == TO_LIMIT) begin
          state_d     = RESP;
          timeout_hit = 1'b1;
        end
      end
      RESP: begin
        state_d     = IDLE;
        bus.err_o   = err_q;
        if (owner_q == OWN_D) begin
          bus.d_ack_o   = 1'b1;
          bus.d_rdata_o = rdata_q;
        end else begin
          bus.i_ack_o   = 1'b1;
          bus.i_rdata_o = rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q  <= OWN_I;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      streak_q <= '0;
      tcnt_q   <= '0;
      i_cnt_q  <= '0;
      d_cnt_q  <= '0;
    end else begin
      if (grant) begin
        owner_q <= grant_side;
        tcnt_q  <= '0;
        err_q   <= 1'b0;
        rdata_q <= '0;
        if (grant_side == OWN_D) begin
          we_q    <= bus.d_we_i;
          addr_q  <= bus.d_addr_i;
          wdata_q <= bus.d_wdata_i;
          if (!bus.i_req_i)              streak_q <= '0;
          else if (streak_q != STREAK_MAX) streak_q <= streak_q + 1'b1;
        end else begin
          we_q     <= 1'b0;
          addr_q   <= bus.i_addr_i;
          wdata_q  <= '0;
          streak_q <= '0;
        end
      end

      if (state_q == BUSY) begin
        if (bus.mem_ack_i) begin
          rdata_q <= bus.mem_rdata_i;
          tcnt_q  <= '0;
        end else if (timeout_hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
          tcnt_q  <= '0;
        end else begin
          tcnt_q  <= tcnt_q + 1'b1;
        end
      end

      // Timed-out transfers still count: the requester did receive an ack.
      if (state_q == RESP) begin
        if (owner_q == OWN_D) d_cnt_q <= d_cnt_q + 1'b1;
        else                  i_cnt_q <= i_cnt_q + 1'b1;
      end
    end
  end

  assign bus.i_cnt_o = i_cnt_q;
  assign bus.d_cnt_o = d_cnt_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported unified memory between the CPU instruction-fetch side (I) and data-access side (D). It accepts one request per side, grants the memory port to one side at a time, and forwards the memory response back to the granted side. D has priority, with a starvation limit that protects I. It also counts completed transfers per side for trace and debug.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MAX_D_STREAK`, 4: maximum consecutive D grants while I is waiting.
- `TIMEOUT`, 255: cycles in BUSY without `mem_ack_i` before an error response.
- `CNT_W`, 16: width of the transfer counters.
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `i_req_i`  in  1  I-side request; held until `i_ack_o`.
- `i_addr_i`  in  ADDR_W  I-side address; read-only side.
- `i_ack_o`  out  1  one-cycle completion pulse to I.
- `i_rdata_o`  out  DATA_W  I-side read data; valid while `i_ack_o` is high.
- `d_req_i`  in  1  D-side request; held until `d_ack_o`.
- `d_we_i`  in  1  D-side write enable.
- `d_addr_i`  in  ADDR_W  D-side address.
- `d_wdata_i`  in  DATA_W  D-side write data.
- `d_ack_o`  out  1  one-cycle completion pulse to D.
- `d_rdata_o`  out  DATA_W  D-side read data; valid while `d_ack_o` is high.
- `err_o`  out  1  high together with an ack when that transfer timed out.
- `mem_req_o`  out  1  memory request; held until `mem_ack_i`.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  ADDR_W  memory address.
- `mem_wdata_o`  out  DATA_W  memory write data.
- `mem_ack_i`  in  1  memory completion; read data is valid in the same cycle.
- `mem_rdata_i`  in  DATA_W  memory read data.
- `i_cnt_o`, `d_cnt_o`  out  CNT_W  completed transfers per side; wrap at 2^CNT_W.

## Operation
- States are IDLE, BUSY, RESP. A registered `owner` bit records the granted side (0 = I, 1 = D).
- IDLE, neither request high: stay in IDLE.
- IDLE, only one request high: grant that side and go to BUSY.
- IDLE, both requests high: grant D, unless the streak counter equals `MAX_D_STREAK`, in which case grant I.
- Streak counter:
  - increments on a D grant while `i_req_i` is high;
  - clears on any I grant;
  - clears on a D grant while `i_req_i` is low;
  - saturates at `MAX_D_STREAK`.
- In BUSY, `mem_*` outputs are driven from the owner's registered request fields, latched at grant. `mem_we_o` is 0 for I.
- In BUSY, `mem_ack_i` high: capture `mem_rdata_i` into the rdata register, go to RESP, and clear the timeout counter.
- In BUSY, the timeout counter reaches `TIMEOUT` with no ack: go to RESP with the error flag set. rdata is 0 and `mem_req_o` drops.
- RESP lasts exactly one cycle:
  - the owner's ack is high;
  - `err_o` carries the error flag;
  - the owner's counter increments, including on error;
  - no arbitration happens in RESP; the next state is IDLE.
- Requesters must drop or update `req` at the clock edge that ends their ack cycle. IDLE samples the new value.
- A `mem_ack_i` seen outside BUSY is ignored.
- Reset, including mid-transfer: state goes to IDLE and the streak, timeout and both transfer counters clear. All outputs are 0 from the cycle after the reset edge onward. No ack is issued for an aborted transfer.

## Timing
- Request high in IDLE cycle t: `mem_req_o` is high from t+1.
- `mem_ack_i` in cycle k ≥ t+1: ack plus rdata at k+1; IDLE at k+2.
- Minimum round trip: request at t, ack at t+2, next grant decided at t+3.
- `mem_*` outputs are constant through BUSY. `mem_req_o` deasserts in the RESP cycle.
- Error case: ack at t+1+TIMEOUT+1 with `err_o` high.
- Reset values: every output 0 (acks, rdata, `err_o`, `mem_*`, counters).

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE / BUSY / RESP);
  - owner constants `OWN_I` and `OWN_D`;
  - the default widths.
- Single module. The grant logic is small enough to stay inline; no sub-module.

## Test plan
- Single I read to `0x10`, memory acks 1 cycle after `mem_req_o` with `0xDEADBEEF` -> `i_ack_o` high for one cycle with `i_rdata_o = 0xDEADBEEF`, `i_cnt_o = 1`, 3-cycle round trip.
- I and D both request in the same IDLE cycle -> D granted first and `mem_addr_o` = D address. I is served after D's RESP.
- Both requests held continuously with `MAX_D_STREAK = 4` -> grant order D,D,D,D,I,D,D,D,D,I.
- D write with `we = 1`, addr `0x40`, data `0x1234` -> `mem_we_o = 1`, `mem_wdata_o = 0x1234`, stable until `mem_ack_i`; `d_ack_o` one cycle later.
- Memory never acks with `TIMEOUT = 8` -> `d_ack_o` and `err_o` high together 10 cycles after the request, `d_rdata_o = 0`, `d_cnt_o` increments.
- `rst_i` asserted mid-BUSY -> next cycle `mem_req_o = 0`, state IDLE, counters 0, no ack pulse.
